bullet_pool: RTL and testbench
==============================

Name: bullet_pool

Overview:
- Parametrised successor to the single-shot player bullet: manages a pool of NUM_BULLETS independent bullets.
- Adds per-frame fire cooldown, lowest-free-slot allocation and per-slot hit clearing from the collision logic.
- Sits between spaceship/input control and the pixel mux. Moves bullets once per frame and renders them with one cycle of registered latency.
- Exports bullet positions for the asteroid/alien collision checker.

Parameters:
NUM_BULLETS, 4, number of bullet slots (1..8)
BULLET_W, 2, bullet width in pixels
BULLET_H, 6, bullet height in pixels
COOLDOWN_FRAMES, 8, frame ticks after a spawn during which fire is rejected (0 = no cooldown)
SPAWN_DX, 7, x offset added to spaceship_x for the spawn column
COLOR, 4'hF, pixel value driven while drawing

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
fire  in  1  fire request level/pulse, sampled every clk
frame  in  1  frame strobe; rising edge detected internally
screen_line  in  1  high while the beam is in visible area
speed  in  8  unsigned pixels per frame tick
screen_x  in  16  signed current beam x
screen_y  in  16  signed current beam y
spaceship_x  in  16  signed ship left x
spaceship_y  in  16  signed ship top y
hit  in  NUM_BULLETS  per-slot clear request from collision logic
active  out  NUM_BULLETS  slot occupied flags
bullet_x  out  16*NUM_BULLETS  signed x per slot, slot i at bits [16i+15:16i]
bullet_y  out  16*NUM_BULLETS  signed y per slot, same packing
fire_ack  out  1  one-cycle pulse: request spawned
fire_drop  out  1  one-cycle pulse: request rejected (cooldown or pool full)
drawing  out  1  beam over any active bullet (registered)
pixel  out  4  COLOR when drawing, else 0

Behaviour:
- Reset (rst=0, async): active=0, all bullet_x/bullet_y=0, cooldown=0, pending=0, frame_d=0, fire_ack=fire_drop=drawing=0, pixel=0.
- Frame tick: tick = frame & ~frame_d, where frame_d is frame registered each clk. All per-frame updates occur on the clk edge at which tick=1; exactly one update per rising frame edge.
- Pending: set by fire=1 on any edge. Cleared at every tick, whether served or rejected. fire=1 on the tick edge itself counts for that tick.
- At tick, each slot is evaluated in this priority order:
  1. hit[i]=1 → active[i]<=0; the slot is not spawn-eligible this tick.
  2. Else if active[i]: ny = bullet_y[i] - {8'b0,speed} (16-bit signed).
     - If ny + BULLET_H <= 0 → active[i]<=0.
     - Else bullet_y[i]<=ny.
  3. Spawn decision, only if pending:
     - If cooldown==0 and a slot is free (active=0 before the tick and hit=0): lowest such index j gets active[j]<=1, bullet_x[j]<=spaceship_x+SPAWN_DX, bullet_y[j]<=spaceship_y-BULLET_H. The new bullet does not move on its spawn tick. cooldown<=COOLDOWN_FRAMES. fire_ack=1 for that cycle.
     - Else fire_drop=1 for that cycle.
  4. Cooldown: if not reloaded, cooldown<=cooldown-1 when nonzero (saturates at 0).
- A slot whose bullet retires on this tick is not reused until the next tick.
- hit[i] outside a tick: clears active[i] at the next clk edge. bullet_x/y hold their values. hit on an inactive slot has no effect.
- Drawing: registered each clk. drawing <= screen_line & OR over i of (active[i] & bullet_x[i] <= screen_x < bullet_x[i]+BULLET_W & bullet_y[i] <= screen_y < bullet_y[i]+BULLET_H). Comparisons are signed. pixel <= COLOR if that term is true, else 0. Latency is 1 clk from screen_x/y.
- speed=0: active bullets hold position indefinitely.
- Negative spawn y (ship near top): bullet is still spawned and retires by the rule in step 2.
- Reset mid-operation clears all slots immediately; no ack or drop pulses are generated.

Test Plan:
- Reset, then fire pulse, speed=1, ship=(100,200), one tick → fire_ack=1, active=0001, slot0=(107,194). After 10 more ticks, slot0 y=184.
- Fire on 4 consecutive ticks with COOLDOWN_FRAMES=8 → first tick ack, next 3 drop, active=0001. After 8 ticks from spawn, fire → ack into slot1.
- COOLDOWN_FRAMES=0, fire held for 5 ticks, speed=0 → slots 0..3 fill in order, fifth tick fire_drop=1, active=1111.
- hit=0010 asserted during slot1 active, no tick → active[1]=0 next edge, others unchanged. Fire at next tick → reuses slot1.
- Bullet at y=3, speed=9, BULLET_H=6 → tick gives ny=-6, ny+6=0 → retired, active bit cleared, no pixel drawn afterwards.
- Beam at (107,194) with screen_line=1 → drawing=1, pixel=F one clk later. screen_line=0 at the same position → drawing=0. Assert rst during operation → all outputs 0 asynchronously.

Source files
------------

// File: rtl/bullet_pool.sv
// bullet_pool: pool of NUM_BULLETS player bullets with fire cooldown,
// lowest-free-slot spawn, per-slot hit clear and registered rendering.
// Ports:
//   in : clk, rst (async, active-low), fire, frame, screen_line, speed[7:0],
//        screen_x/y, spaceship_x/y (signed 16), hit[NUM_BULLETS-1:0]
//   out: active, bullet_x/bullet_y (16 bits per slot, slot i at [16i+15:16i]),
//        fire_ack, fire_drop, drawing, pixel[3:0]
module bullet_pool #(
    parameter int NUM_BULLETS = 4,
    parameter int BULLET_W = 2,
    parameter int BULLET_H = 6,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int SPAWN_DX = 7,
    parameter logic [3:0] COLOR = 4'hF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fire,
    input  logic                     frame,
    input  logic                     screen_line,
    input  logic [7:0]               speed,
    input  logic [15:0]              screen_x,
    input  logic [15:0]              screen_y,
    input  logic [15:0]              spaceship_x,
    input  logic [15:0]              spaceship_y,
    input  logic [NUM_BULLETS-1:0]   hit,
    output logic [NUM_BULLETS-1:0]   active,
    output logic [16*NUM_BULLETS-1:0] bullet_x,
    output logic [16*NUM_BULLETS-1:0] bullet_y,
    output logic                     fire_ack,
    output logic                     fire_drop,
    output logic                     drawing,
    output logic [3:0]               pixel
);

    localparam int CW = (COOLDOWN_FRAMES > 0) ?
                        $clog2(COOLDOWN_FRAMES + 1) : 1;

    logic [15:0] bx [NUM_BULLETS];
    logic [15:0] by [NUM_BULLETS];
    logic [CW-1:0] cooldown;
    logic pending;
    logic frame_d;

    logic tick;
    logic req;
    logic spawn;
    logic [NUM_BULLETS-1:0] free;
    logic [NUM_BULLETS-1:0] grant;
    logic [NUM_BULLETS-1:0] retire;
    logic [NUM_BULLETS-1:0] over;
    logic [15:0] ny [NUM_BULLETS];
    logic [16:0] nyh [NUM_BULLETS];
    logic signed [16:0] sx;
    logic signed [16:0] sy;
    logic signed [16:0] bxs [NUM_BULLETS];
    logic signed [16:0] bys [NUM_BULLETS];
    logic [15:0] spawn_x;
    logic [15:0] spawn_y;
    logic draw_hit;

    always_comb begin
        tick    = frame & ~frame_d;
        req     = pending | fire;
        free    = ~active & ~hit;
        // isolate lowest set bit of free
        grant   = free & (~free + NUM_BULLETS'(1));
        spawn   = req & (cooldown == '0) & (|free);
        spawn_x = spaceship_x + 16'(SPAWN_DX);
        spawn_y = spaceship_y - 16'(BULLET_H);
        sx      = {screen_x[15], screen_x};
        sy      = {screen_y[15], screen_y};
        for (int i = 0; i < NUM_BULLETS; i++) begin
            ny[i]     = by[i] - {8'b0, speed};
            // 17-bit so the retire test cannot wrap
            nyh[i]    = {ny[i][15], ny[i]} + 17'(BULLET_H);
            retire[i] = nyh[i][16] | (nyh[i] == '0);
            bxs[i]    = {bx[i][15], bx[i]};
            bys[i]    = {by[i][15], by[i]};
            over[i]   = active[i] &
                        (sx >= bxs[i]) & (sx < bxs[i] + 17'(BULLET_W)) &
                        (sy >= bys[i]) & (sy < bys[i] + 17'(BULLET_H));
        end
        draw_hit = screen_line & (|over);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active    <= '0;
            cooldown  <= '0;
            pending   <= 1'b0;
            frame_d   <= 1'b0;
            fire_ack  <= 1'b0;
            fire_drop <= 1'b0;
            drawing   <= 1'b0;
            pixel     <= 4'h0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                bx[i] <= '0;
                by[i] <= '0;
            end
        end else begin
            frame_d   <= frame;
            fire_ack  <= 1'b0;
            fire_drop <= 1'b0;
            drawing   <= draw_hit;
            pixel     <= draw_hit ? COLOR : 4'h0;
            if (tick) begin
                pending <= 1'b0;
                for (int i = 0; i < NUM_BULLETS; i++) begin
                    if (hit[i]) begin
                        active[i] <= 1'b0;
                    end else if (active[i]) begin
                        if (retire[i]) active[i] <= 1'b0;
                        else           by[i] <= ny[i];
                    end else if (spawn & grant[i]) begin
                        active[i] <= 1'b1;
                        bx[i]     <= spawn_x;
                        by[i]     <= spawn_y;
                    end
                end
                if (spawn)
                    cooldown <= CW'(COOLDOWN_FRAMES);
                else if (cooldown != '0)
                    cooldown <= cooldown - CW'(1);
                fire_ack  <= spawn;
                fire_drop <= req & ~spawn;
            end else begin
                if (fire) pending <= 1'b1;
                active <= active & ~hit;
            end
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_pack
        assign bullet_x[16*g +: 16] = bx[g];
        assign bullet_y[16*g +: 16] = by[g];
    end

endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: directed table, hand sequences and randomized run
// checked every cycle against a behavioural model of the bullet pool.
module tb_bullet_pool;

    localparam int N = 4;

    logic clk = 0;
    logic rst = 1;
    logic fire = 0;
    logic frame = 0;
    logic screen_line = 0;
    logic [7:0] speed = 0;
    logic [15:0] screen_x = 0;
    logic [15:0] screen_y = 0;
    logic [15:0] spaceship_x = 0;
    logic [15:0] spaceship_y = 0;
    logic [N-1:0] hit = 0;
    logic [N-1:0] active;
    logic [16*N-1:0] bullet_x;
    logic [16*N-1:0] bullet_y;
    logic fire_ack;
    logic fire_drop;
    logic drawing;
    logic [3:0] pixel;

    bullet_pool dut (
        .clk(clk), .rst(rst), .fire(fire), .frame(frame),
        .screen_line(screen_line), .speed(speed),
        .screen_x(screen_x), .screen_y(screen_y),
        .spaceship_x(spaceship_x), .spaceship_y(spaceship_y),
        .hit(hit), .active(active),
        .bullet_x(bullet_x), .bullet_y(bullet_y),
        .fire_ack(fire_ack), .fire_drop(fire_drop),
        .drawing(drawing), .pixel(pixel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model state
    bit m_act [N];
    int m_x [N];
    int m_y [N];
    int m_cd;
    bit m_pend, m_fd, m_ack, m_drop, m_draw;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int sx_of(input int i);
        logic [15:0] v;
        v = bullet_x[16*i +: 16];
        return int'($signed(v));
    endfunction

    function automatic int sy_of(input int i);
        logic [15:0] v;
        v = bullet_y[16*i +: 16];
        return int'($signed(v));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_cd = 0; m_pend = 0; m_fd = 0;
        m_ack = 0; m_drop = 0; m_draw = 0;
    endtask

    // one clock edge of the spec's rules, using inputs present now
    task automatic model_step();
        bit tk, rq, d;
        int j, ny, px, py;
        px = int'($signed(screen_x));
        py = int'($signed(screen_y));
        d = 0;
        for (int i = 0; i < N; i++)
            if (m_act[i] && px >= m_x[i] && px < m_x[i] + 2 &&
                py >= m_y[i] && py < m_y[i] + 6) d = 1;
        m_draw = screen_line && d;
        tk = frame && !m_fd;
        m_fd = frame;
        m_ack = 0;
        m_drop = 0;
        if (tk) begin
            rq = m_pend || fire;
            m_pend = 0;
            j = -1;
            for (int i = 0; i < N; i++)
                if (j < 0 && !m_act[i] && !hit[i]) j = i;
            for (int i = 0; i < N; i++) begin
                if (hit[i]) m_act[i] = 0;
                else if (m_act[i]) begin
                    ny = m_y[i] - int'(speed);
                    if (ny + 6 <= 0) m_act[i] = 0;
                    else m_y[i] = ny;
                end
            end
            if (rq && m_cd == 0 && j >= 0) begin
                m_act[j] = 1;
                m_x[j] = int'($signed(spaceship_x)) + 7;
                m_y[j] = int'($signed(spaceship_y)) - 6;
                m_cd = 8;
                m_ack = 1;
            end else begin
                if (rq) m_drop = 1;
                if (m_cd > 0) m_cd--;
            end
        end else begin
            if (fire) m_pend = 1;
            for (int i = 0; i < N; i++) if (hit[i]) m_act[i] = 0;
        end
    endtask

    task automatic cyc();
        logic [N-1:0] ea;
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) ea[i] = m_act[i];
        chk("m_active", active, ea);
        chk("m_ack", fire_ack, m_ack);
        chk("m_drop", fire_drop, m_drop);
        chk("m_drawing", drawing, m_draw);
        chk("m_pixel", pixel, m_draw ? 15 : 0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("m_x%0d", i), sx_of(i), m_x[i]);
            chk($sformatf("m_y%0d", i), sy_of(i), m_y[i]);
        end
    endtask

    task automatic tick(input bit f, output bit a, output bit d);
        fire = f;
        frame = 1;
        cyc();
        a = fire_ack;
        d = fire_drop;
        fire = 0;
        frame = 0;
        cyc();
    endtask

    task automatic draw_at(input int x, input int y, input bit ln,
                           input bit exp, input string name);
        screen_x = 16'(x);
        screen_y = 16'(y);
        screen_line = ln;
        cyc();
        chk(name, drawing, exp);
        chk({name, "_pix"}, pixel, exp ? 15 : 0);
        screen_line = 0;
    endtask

    typedef struct {
        bit f;
        logic [N-1:0] act;
        bit ack;
        bit drop;
    } vec_t;

    vec_t tbl [11];
    bit a, d;

    initial begin
        tbl[0] = '{1, 4'b0001, 1, 0};
        for (int i = 1; i <= 3; i++) tbl[i] = '{1, 4'b0001, 0, 1};
        for (int i = 4; i <= 8; i++) tbl[i] = '{0, 4'b0001, 0, 0};
        tbl[9]  = '{1, 4'b0011, 1, 0};
        tbl[10] = '{0, 4'b0011, 0, 0};

        #2 rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_active", active, 0);
        chk("rst_bx", bullet_x, 0);
        chk("rst_by", bullet_y, 0);
        chk("rst_ack", fire_ack, 0);
        chk("rst_drop", fire_drop, 0);
        chk("rst_pixel", pixel, 0);
        @(negedge clk);
        rst = 1;
        model_reset();

        speed = 1;
        spaceship_x = 100;
        spaceship_y = 200;
        for (int k = 0; k < 11; k++) begin
            tick(tbl[k].f, a, d);
            chk($sformatf("tbl%0d_ack", k), a, tbl[k].ack);
            chk($sformatf("tbl%0d_drop", k), d, tbl[k].drop);
            chk($sformatf("tbl%0d_act", k), active, tbl[k].act);
        end
        chk("slot0_x", sx_of(0), 107);
        chk("slot0_y", sy_of(0), 184);
        chk("slot1_y", sy_of(1), 193);

        draw_at(107, 184, 1, 1, "draw_tl");
        draw_at(109, 184, 1, 0, "draw_xedge");
        draw_at(108, 189, 1, 1, "draw_br");
        draw_at(108, 190, 1, 0, "draw_yedge");
        draw_at(107, 193, 1, 1, "draw_s1");
        draw_at(107, 184, 0, 0, "draw_noline");

        hit = 4'b0010;
        cyc();
        hit = 0;
        chk("hit_act", active, 4'b0001);
        chk("hit_y1", sy_of(1), 193);

        repeat (7) tick(0, a, d);
        tick(1, a, d);
        chk("reuse_ack", a, 1);
        chk("reuse_act", active, 4'b0011);
        chk("reuse_y1", sy_of(1), 194);
        chk("reuse_y0", sy_of(0), 176);

        speed = 0;
        repeat (8) tick(0, a, d);
        tick(1, a, d);
        chk("fill2_ack", a, 1);
        chk("fill2_act", active, 4'b0111);
        repeat (8) tick(0, a, d);
        tick(1, a, d);
        chk("fill3_ack", a, 1);
        chk("fill3_act", active, 4'b1111);
        repeat (8) tick(0, a, d);
        tick(1, a, d);
        chk("full_ack", a, 0);
        chk("full_drop", d, 1);
        chk("full_act", active, 4'b1111);
        chk("hold_y0", sy_of(0), 176);

        #1 rst = 0;
        #1;
        chk("arst_active", active, 0);
        chk("arst_bx", bullet_x, 0);
        chk("arst_by", bullet_y, 0);
        chk("arst_draw", drawing, 0);
        @(negedge clk);
        rst = 1;
        model_reset();

        spaceship_y = 9;
        speed = 9;
        tick(1, a, d);
        chk("ret_spawn_ack", a, 1);
        chk("ret_spawn_y", sy_of(0), 3);
        draw_at(107, 3, 1, 1, "ret_draw_before");
        tick(0, a, d);
        chk("ret_act", active, 0);
        draw_at(107, 3, 1, 0, "ret_draw_after");

        for (int c = 0; c < 2000; c++) begin
            int k;
            fire = ($urandom % 4) == 0;
            frame = ($urandom % 3) == 0;
            for (int i = 0; i < N; i++) hit[i] = ($urandom % 16) == 0;
            speed = 8'($urandom % 12);
            spaceship_x = 16'($urandom % 600);
            spaceship_y = 16'($urandom % 300);
            screen_line = ($urandom % 4) != 0;
            if ($urandom % 2) begin
                k = int'($urandom % N);
                screen_x = 16'(m_x[k] + int'($urandom % 4) - 1);
                screen_y = 16'(m_y[k] + int'($urandom % 8) - 1);
            end else begin
                screen_x = 16'($urandom % 640);
                screen_y = 16'($urandom % 480);
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
